// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: register/tag widths, PU id width, default PU
// count and the common-data-bus packet seen by the PRF, reservation stations
// and ROB.
package rv32i_pkg;

   localparam int unsigned REG_FILE_BW         = 32;
   localparam int unsigned PHY_REG_FILE_IDX_BW = 6;
   // Wide enough for up to 8 processing units; NUM_PU may be smaller.
   localparam int unsigned PU_ID_BW            = 3;
   localparam int unsigned NUM_PU_DEFAULT      = 2;

   typedef struct packed {
      logic                           vld;
      logic [PU_ID_BW-1:0]            pu_id;
      logic [PHY_REG_FILE_IDX_BW-1:0] tag;
      logic [REG_FILE_BW-1:0]         data;
   } cdb_pkt_t;

   // Round-robin successor; wraps at n rather than at 2**PU_ID_BW.
   function automatic logic [PU_ID_BW-1:0] rr_next(input logic [PU_ID_BW-1:0] id,
                                                    input int unsigned n);
      if (32'(id) + 32'd1 >= n) return '0;
      return PU_ID_BW'(32'(id) + 32'd1);
   endfunction

endpackage

// File: rtl/rv32i_cdb_arbiter_if.sv
// PU-to-CDB writeback bus.
//   i_pu_vld/i_pu_tag/i_pu_data : per-PU results offered to the arbiter
//   o_pu_rdy                    : per-PU one-hot grant
//   i_flush, i_cdb_rdy          : ROB flush and consumer accept
//   o_cdb_*                     : registered broadcast
// master = the arbiter, slave = PUs plus consumer.
interface rv32i_cdb_arbiter_if
   import rv32i_pkg::*;
#(
   parameter int unsigned NUM_PU  = NUM_PU_DEFAULT,
   parameter int unsigned DATA_BW = REG_FILE_BW,
   parameter int unsigned TAG_BW  = PHY_REG_FILE_IDX_BW
) ();

   logic [NUM_PU-1:0]              i_pu_vld;
   logic [NUM_PU-1:0][TAG_BW-1:0]  i_pu_tag;
   logic [NUM_PU-1:0][DATA_BW-1:0] i_pu_data;
   logic [NUM_PU-1:0]              o_pu_rdy;
   logic                           i_flush;
   logic                           i_cdb_rdy;
   logic                           o_cdb_vld;
   logic [PU_ID_BW-1:0]            o_cdb_pu_id;
   logic [TAG_BW-1:0]              o_cdb_tag;
   logic [DATA_BW-1:0]             o_cdb_data;

   modport master (
      input  i_pu_vld, i_pu_tag, i_pu_data, i_flush, i_cdb_rdy,
      output o_pu_rdy, o_cdb_vld, o_cdb_pu_id, o_cdb_tag, o_cdb_data
   );

   modport slave (
      output i_pu_vld, i_pu_tag, i_pu_data, i_flush, i_cdb_rdy,
      input  o_pu_rdy, o_cdb_vld, o_cdb_pu_id, o_cdb_tag, o_cdb_data
   );

endinterface

// File: rtl/rv32i_rr_arbiter.sv
// Round-robin one-hot arbiter with its own pointer.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   req      : request vector
//   en       : grant/advance enable; no grant and no pointer move when low
//   gnt      : one-hot grant (combinational)
module rv32i_rr_arbiter
   import rv32i_pkg::*;
#(
   parameter int unsigned N = NUM_PU_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   logic [PU_ID_BW-1:0] ptr;
   logic [PU_ID_BW-1:0] gnt_id_c;
   logic                found_c;

   // Two passes: indices at/above ptr first, then wrap to those below it.
   always_comb begin
      gnt      = '0;
      gnt_id_c = '0;
      found_c  = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (en && !found_c && req[k] && k >= 32'(ptr)) begin
            gnt[k]   = 1'b1;
            gnt_id_c = PU_ID_BW'(k);
            found_c  = 1'b1;
         end
      end
      for (int unsigned k = 0; k < N; k++) begin
         if (en && !found_c && req[k] && k < 32'(ptr)) begin
            gnt[k]   = 1'b1;
            gnt_id_c = PU_ID_BW'(k);
            found_c  = 1'b1;
         end
      end
   end

   // Pointer moves past the winner only on an actual grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ptr <= '0;
      else if (found_c) ptr <= rr_next(gnt_id_c, N);
   end

endmodule

// File: rtl/rv32i_cdb_arbiter.sv
// Common-data-bus writeback arbiter: picks one completed PU result per cycle,
// registers it and holds it until the consumer accepts it.
//   clk, rst : core clock, async active-high reset
//   bus      : rv32i_cdb_arbiter_if.master (PU requests/grants, flush,
//              consumer ready, registered CDB broadcast)
// Build option RV32I_CDB_FIXED_PRIO_EN: lowest-indexed valid PU always wins
// and no round-robin pointer exists; default is round-robin.
module rv32i_cdb_arbiter
   import rv32i_pkg::*;
#(
   parameter int unsigned NUM_PU  = NUM_PU_DEFAULT,
   parameter int unsigned DATA_BW = REG_FILE_BW,
   parameter int unsigned TAG_BW  = PHY_REG_FILE_IDX_BW
) (
   input logic                 clk,
   input logic                 rst,
   rv32i_cdb_arbiter_if.master bus
);

   logic                free_c;
   logic                grant_en_c;
   logic [NUM_PU-1:0]   gnt_c;
   logic [PU_ID_BW-1:0] sel_id_c;
   logic [TAG_BW-1:0]   sel_tag_c;
   logic [DATA_BW-1:0]  sel_data_c;

   logic                cdb_vld;
   logic [PU_ID_BW-1:0] cdb_pu_id;
   logic [TAG_BW-1:0]   cdb_tag;
   logic [DATA_BW-1:0]  cdb_data;

   // rst in the enable keeps o_pu_rdy low for the whole reset.
   assign free_c     = !cdb_vld || bus.i_cdb_rdy;
   assign grant_en_c = free_c && !bus.i_flush && !rst;

`ifdef RV32I_CDB_FIXED_PRIO_EN
   // Pure priority encode, PU 0 highest.
   logic found_c;
   always_comb begin
      gnt_c   = '0;
      found_c = 1'b0;
      for (int unsigned k = 0; k < NUM_PU; k++) begin
         if (grant_en_c && !found_c && bus.i_pu_vld[k]) begin
            gnt_c[k] = 1'b1;
            found_c  = 1'b1;
         end
      end
   end
`else
   rv32i_rr_arbiter #(.N(NUM_PU)) u_rr (
      .clk (clk),
      .rst (rst),
      .req (bus.i_pu_vld),
      .en  (grant_en_c),
      .gnt (gnt_c)
   );
`endif

   // One-hot AND-OR mux of the winning PU's payload.
   always_comb begin
      sel_id_c   = '0;
      sel_tag_c  = '0;
      sel_data_c = '0;
      for (int unsigned k = 0; k < NUM_PU; k++) begin
         if (gnt_c[k]) begin
            sel_id_c   = sel_id_c   | PU_ID_BW'(k);
            sel_tag_c  = sel_tag_c  | bus.i_pu_tag[k];
            sel_data_c = sel_data_c | bus.i_pu_data[k];
         end
      end
   end

   // Output register: flush empties, a free slot loads or empties, stall holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_vld   <= 1'b0;
         cdb_pu_id <= '0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
      end else if (bus.i_flush) begin
         cdb_vld <= 1'b0;
      end else if (free_c) begin
         cdb_vld <= |gnt_c;
         if (|gnt_c) begin
            cdb_pu_id <= sel_id_c;
            cdb_tag   <= sel_tag_c;
            cdb_data  <= sel_data_c;
         end
      end
   end

   assign bus.o_pu_rdy    = gnt_c;
   assign bus.o_cdb_vld   = cdb_vld;
   assign bus.o_cdb_pu_id = cdb_pu_id;
   assign bus.o_cdb_tag   = cdb_tag;
   assign bus.o_cdb_data  = cdb_data;

endmodule

// File: tb/tb_rv32i_cdb_arbiter.sv
// Self-checking bench for rv32i_cdb_arbiter: a directed vector table, a reset
// corner sequence, then a random phase checked against a reference model and
// a scoreboard of expected broadcasts.
module tb_rv32i_cdb_arbiter;
   import rv32i_pkg::*;

   localparam int unsigned NPU = 2;
   localparam int unsigned DW  = 32;
   localparam int unsigned TW  = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv32i_cdb_arbiter_if #(.NUM_PU(NPU), .DATA_BW(DW), .TAG_BW(TW)) bus ();

   rv32i_cdb_arbiter #(.NUM_PU(NPU), .DATA_BW(DW), .TAG_BW(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  vld;
      logic [5:0]  t0, t1;
      logic [31:0] d0, d1;
      logic        rdy, fl;
      logic [1:0]  e_rdy;
      logic        e_vld;
      logic [2:0]  e_id;
      logic [5:0]  e_tag;
      logic [31:0] e_data;
   } vec_t;

   vec_t     vecs[$];
   cdb_pkt_t sb[$];
   int       n_vec = 0;
   int       n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] vld, input logic [5:0] t0, input logic [31:0] d0,
                        input logic [5:0] t1, input logic [31:0] d1,
                        input logic rdy, input logic fl);
      bus.i_pu_vld     = vld;
      bus.i_pu_tag[0]  = t0;
      bus.i_pu_data[0] = d0;
      bus.i_pu_tag[1]  = t1;
      bus.i_pu_data[1] = d1;
      bus.i_cdb_rdy    = rdy;
      bus.i_flush      = fl;
   endtask

   function automatic void add(input logic [1:0] vld, input logic [5:0] t0, input logic [31:0] d0,
                               input logic [5:0] t1, input logic [31:0] d1,
                               input logic rdy, input logic fl, input logic [1:0] e_rdy,
                               input logic e_vld, input logic [2:0] e_id,
                               input logic [5:0] e_tag, input logic [31:0] e_data);
      vec_t v;
      v.vld = vld; v.t0 = t0; v.d0 = d0; v.t1 = t1; v.d1 = d1;
      v.rdy = rdy; v.fl = fl; v.e_rdy = e_rdy; v.e_vld = e_vld;
      v.e_id = e_id; v.e_tag = e_tag; v.e_data = e_data;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  pv;
      logic [5:0]  ptag[2];
      logic [31:0] pdata[2];
      int          m_ptr;
      logic        m_vld;
      logic        rdy, fl, found;
      logic [1:0]  e_gnt;
      int          win;
      cdb_pkt_t    pkt;

      //            vld    t0  d0    t1  d1             rdy fl  e_rdy vld id tag data
`ifdef RV32I_CDB_FIXED_PRIO_EN
      add(2'b01, 5, 14,  0, 0,            1, 0, 2'b01, 1, 0, 5, 14);
      add(2'b00, 5, 14,  0, 0,            1, 0, 2'b00, 0, 0, 0, 0);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
      add(2'b10, 1, 100, 2, 200,          1, 0, 2'b10, 1, 1, 2, 200);
      add(2'b11, 1, 100, 2, 200,          0, 1, 2'b00, 0, 0, 0, 0);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
`else
      add(2'b01, 5, 14,  0, 0,            1, 0, 2'b01, 1, 0, 5, 14);
      add(2'b00, 5, 14,  0, 0,            1, 0, 2'b00, 0, 0, 0, 0);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b10, 1, 1, 2, 200);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b10, 1, 1, 2, 200);
      add(2'b11, 1, 100, 2, 200,          1, 0, 2'b01, 1, 0, 1, 100);
      add(2'b10, 3, 33,  9, 32'hFFFF_FFEB, 1, 0, 2'b10, 1, 1, 9, 32'hFFFF_FFEB);
      add(2'b01, 3, 33,  9, 32'hFFFF_FFEB, 0, 0, 2'b00, 1, 1, 9, 32'hFFFF_FFEB);
      add(2'b01, 3, 33,  9, 32'hFFFF_FFEB, 0, 0, 2'b00, 1, 1, 9, 32'hFFFF_FFEB);
      add(2'b01, 3, 33,  9, 32'hFFFF_FFEB, 0, 0, 2'b00, 1, 1, 9, 32'hFFFF_FFEB);
      add(2'b01, 3, 33,  9, 32'hFFFF_FFEB, 1, 0, 2'b01, 1, 0, 3, 33);
      add(2'b11, 3, 33,  4, 44,           0, 1, 2'b00, 0, 0, 0, 0);
      add(2'b11, 3, 33,  4, 44,           1, 0, 2'b10, 1, 1, 4, 44);
      add(2'b11, 3, 33,  4, 44,           1, 1, 2'b00, 0, 0, 0, 0);
      add(2'b01, 3, 33,  4, 44,           0, 0, 2'b01, 1, 0, 3, 33);
`endif

      // Reset state, with both PUs requesting to show grants stay off.
      rst = 1'b1;
      drive(2'b11, 7, 70, 8, 80, 1, 0);
      #1;
      chk("reset_rdy",   64'(bus.o_pu_rdy),    64'd0);
      chk("reset_vld",   64'(bus.o_cdb_vld),   64'd0);
      chk("reset_id",    64'(bus.o_cdb_pu_id), 64'd0);
      chk("reset_tag",   64'(bus.o_cdb_tag),   64'd0);
      chk("reset_data",  64'(bus.o_cdb_data),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].vld, vecs[i].t0, vecs[i].d0, vecs[i].t1, vecs[i].d1,
               vecs[i].rdy, vecs[i].fl);
         @(negedge clk);
         chk($sformatf("vec%0d_rdy", i), 64'(bus.o_pu_rdy), 64'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_vld", i), 64'(bus.o_cdb_vld), 64'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk($sformatf("vec%0d_id", i),   64'(bus.o_cdb_pu_id), 64'(vecs[i].e_id));
            chk($sformatf("vec%0d_tag", i),  64'(bus.o_cdb_tag),   64'(vecs[i].e_tag));
            chk($sformatf("vec%0d_data", i), 64'(bus.o_cdb_data),  64'(vecs[i].e_data));
         end
      end

      // Reset in mid-broadcast clears at once; first grant afterwards is PU0.
      drive(2'b11, 11, 110, 12, 120, 1, 0);
      rst = 1'b1;
      #1;
      chk("midrst_vld",  64'(bus.o_cdb_vld),  64'd0);
      chk("midrst_rdy",  64'(bus.o_pu_rdy),   64'd0);
      chk("midrst_tag",  64'(bus.o_cdb_tag),  64'd0);
      chk("midrst_data", 64'(bus.o_cdb_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst_rdy", 64'(bus.o_pu_rdy), 64'b01);
      @(posedge clk);
      #1;
      chk("postrst_vld", 64'(bus.o_cdb_vld),   64'd1);
      chk("postrst_id",  64'(bus.o_cdb_pu_id), 64'd0);
      chk("postrst_tag", 64'(bus.o_cdb_tag),   64'd11);

      // Drain the bus so the random phase starts empty.
      drive(2'b00, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      chk("drain_vld", 64'(bus.o_cdb_vld), 64'd0);

      // Random phase: reference model predicts grants, scoreboard the broadcasts.
      m_ptr = 1;
      m_vld = 1'b0;
      pv    = 2'b00;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pv[k] && ($urandom_range(0, 1) == 1)) begin
               pv[k]    = 1'b1;
               ptag[k]  = 6'($urandom);
               pdata[k] = $urandom;
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 15) == 0);
         drive(pv, ptag[0], pdata[0], ptag[1], pdata[1], rdy, fl);
         @(negedge clk);

         chk("rnd_vld", 64'(bus.o_cdb_vld), 64'(m_vld));
         if (m_vld) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rnd_sb: bus valid but scoreboard empty at %0t", $time);
            end else begin
               chk("rnd_id",   64'(bus.o_cdb_pu_id), 64'(sb[0].pu_id));
               chk("rnd_tag",  64'(bus.o_cdb_tag),   64'(sb[0].tag));
               chk("rnd_data", 64'(bus.o_cdb_data),  64'(sb[0].data));
            end
         end

         e_gnt = 2'b00;
         found = 1'b0;
         win   = 0;
         if ((!m_vld || rdy) && !fl) begin
            for (int j = 0; j < 2; j++) begin
               int k;
`ifdef RV32I_CDB_FIXED_PRIO_EN
               k = j;
`else
               k = (m_ptr + j) % 2;
`endif
               if (!found && pv[k]) begin
                  found    = 1'b1;
                  win      = k;
                  e_gnt[k] = 1'b1;
               end
            end
         end
         chk("rnd_rdy", 64'(bus.o_pu_rdy), 64'(e_gnt));

         if (m_vld && (rdy || fl) && sb.size() != 0) void'(sb.pop_front());
         if (fl) begin
            m_vld = 1'b0;
         end else if (!m_vld || rdy) begin
            m_vld = found;
            if (found) begin
               pkt.vld   = 1'b1;
               pkt.pu_id = 3'(win);
               pkt.tag   = ptag[win];
               pkt.data  = pdata[win];
               sb.push_back(pkt);
               pv[win] = 1'b0;
               m_ptr   = (win + 1) % 2;
            end
         end
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv32i_cdb_arbiter.md
# rv32i_cdb_arbiter

Common-data-bus (writeback) arbiter for the rv32i out-of-order core. Sits between the processing units (PU 0 = ALU, PU 1 = multiplier, further PUs by parameter) and the single result broadcast bus that feeds the physical register file, the reservation-station wakeup logic and the reorder buffer. Each cycle it selects at most one completed PU result round-robin, registers it, and holds it on the bus until the consumer accepts it.

## Interface
- NUM_PU, default 2: number of requesting processing units; must be at least 2.
- DATA_BW, default REG_FILE_BW (32): result width.
- TAG_BW, default PHY_REG_FILE_IDX_BW: destination physical-register tag width.
- clk  in  1  core clock; everything is rising-edge triggered.
- rst  in  1  asynchronous, active-high reset.
- i_pu_vld  in  NUM_PU  per-PU result valid.
- i_pu_tag  in  NUM_PU x TAG_BW  per-PU destination physical tag.
- i_pu_data  in  NUM_PU x DATA_BW  per-PU result value.
- o_pu_rdy  out  NUM_PU  per-PU grant; a transfer occurs when i_pu_vld[k] and o_pu_rdy[k] are both high.
- i_flush  in  1  pipeline flush from the ROB.
- i_cdb_rdy  in  1  the consumer accepts o_cdb_* this cycle.
- o_cdb_vld  out  1  broadcast valid.
- o_cdb_pu_id  out  PU_ID_BW  PU that produced the broadcast result.
- o_cdb_tag  out  TAG_BW  broadcast destination tag.
- o_cdb_data  out  DATA_BW  broadcast result value.

## Operation
- The block contains one output register (o_cdb_*) and a round-robin pointer rr_ptr (PU_ID_BW bits).
- Slot free: free = !o_cdb_vld || i_cdb_rdy.
- Grant: if free and !i_flush, o_pu_rdy is one-hot on the first PU with i_pu_vld set, searching from rr_ptr upward with wrap-around. Otherwise o_pu_rdy is all zeros.
- o_pu_rdy is combinational from i_pu_vld. A PU must not make i_pu_vld depend on o_pu_rdy. A PU holds vld, tag and data stable until it is granted.
- On a transfer from PU k:
  - o_cdb_vld becomes 1.
  - o_cdb_pu_id becomes k; o_cdb_tag and o_cdb_data take PU k's tag and data.
  - rr_ptr becomes (k+1) mod NUM_PU.
- Free with no request (and no flush): o_cdb_vld becomes 0. The data fields may hold stale values.
- Stall: when o_cdb_vld=1 and i_cdb_rdy=0, all o_cdb_* outputs hold and no grant is issued.
- Flush: o_cdb_vld becomes 0 on the next edge regardless of i_cdb_rdy. No grant is issued in the flush cycle and rr_ptr is unchanged.
- Arithmetic: rr_ptr wraps at NUM_PU, not at 2^PU_ID_BW. PU indices at or above NUM_PU are never granted.

## Timing
- Reset values:
  - o_cdb_vld=0; o_cdb_pu_id, o_cdb_tag and o_cdb_data = 0; rr_ptr=0.
  - o_pu_rdy is 0 for as long as rst is asserted.
- Latency: transfer at edge N produces o_cdb_vld=1 in cycle N+1.
- Throughput: one result per cycle while i_cdb_rdy=1. Back-to-back grants need no bubble.
- Simultaneous i_cdb_rdy=1 with a new grant: the old result retires and the new one loads on the same edge.
- Simultaneous i_flush and i_cdb_rdy: flush wins, so the bus empties and no new load occurs.
- Reset asserted mid-broadcast clears the output register immediately (asynchronous). The first grant after release starts from PU 0.

## Configuration
- RV32I_CDB_FIXED_PRIO_EN:
  - Defined: grant always goes to the lowest-indexed valid PU. rr_ptr is removed and o_pu_rdy is a pure priority encode.
  - Undefined (default): round-robin as described in Operation.
- All other behaviour is identical in both configurations.

## Structure
- rv32i_pkg holds the shared definitions:
  - PU_ID_BW, REG_FILE_BW and PHY_REG_FILE_IDX_BW.
  - NUM_PU_DEFAULT.
  - A packed struct cdb_pkt_t containing vld, pu_id, tag and data. This struct is shared with the register file, the reservation stations and the ROB.
- Sub-module rv32i_rr_arbiter holds the round-robin grant logic and the pointer. It is parameterised on width, takes a request vector and an advance-enable, and outputs a one-hot grant. rv32i_cdb_arbiter instantiates it once and adds the output register, stall and flush handling.

## Test plan
- Reset, then PU0 presents tag=5, data=14 with i_cdb_rdy=1 -> o_pu_rdy=01 in that cycle; the next cycle shows o_cdb_vld=1, pu_id=0, tag=5, data=14; o_cdb_vld returns to 0 after that.
- PU0 and PU1 held valid continuously with i_cdb_rdy=1 -> grants alternate 01,10,01,10 and the bus shows pu_id 0,1,0,1 with no bubbles.
- PU1 granted (tag=9, data=-21), then i_cdb_rdy=0 for 3 cycles with PU0 valid -> o_cdb_* holds tag 9 and o_pu_rdy=00 for 3 cycles; when i_cdb_rdy rises, PU0 is granted in that same cycle.
- i_flush pulsed while o_cdb_vld=1 and both PUs are valid -> next cycle o_cdb_vld=0, no grant in the flush cycle, rr_ptr unchanged.
- rst asserted while o_cdb_vld=1 with rr_ptr=1 -> o_cdb_vld=0 immediately; after release, PU0 and PU1 both valid -> PU0 is granted first.
- With RV32I_CDB_FIXED_PRIO_EN defined, PU0 and PU1 held valid -> PU0 is granted every cycle and PU1 is never granted until PU0 drops vld.
